// File: rtl/prog_loader.sv
// Boot loader: streams an image into memory port A, keeps a running checksum,
// optionally reads the image back to verify it, and releases the core only once it is good.
module prog_loader #(
  parameter int unsigned   AW        = 32,
  parameter int unsigned   DW        = 32,
  parameter logic [AW-1:0] BASE_ADDR = '0,
  parameter int unsigned   ADDR_STEP = 4,
  parameter int unsigned   MAX_WORDS = 1024,
  parameter bit            VERIFY    = 1'b1,
  parameter int unsigned   RD_LAT    = 1,
  localparam int unsigned  CW        = $clog2(MAX_WORDS) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          ld_valid,
  input  logic [DW-1:0] ld_data,
  input  logic          ld_last,
  output logic          ld_ready,
  output logic          mem_en_w,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          core_hold,
  output logic          done,
  output logic          err,
  output logic [1:0]    err_code,
  output logic [CW-1:0] word_cnt,
  output logic [DW-1:0] checksum
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_VERIFY, S_DONE, S_ERROR} state_e;

  localparam logic [AW-1:0] STEP     = AW'(ADDR_STEP);
  localparam logic [CW-1:0] LAST_IDX = CW'(MAX_WORDS - 1);

  state_e          state_q, state_d;
  logic [CW-1:0]   word_cnt_q, word_cnt_d;
  logic [DW-1:0]   checksum_q, checksum_d;
  logic            mem_en_w_q, mem_en_w_d;
  logic [AW-1:0]   mem_addr_q, mem_addr_d;
  logic [DW-1:0]   mem_wdata_q, mem_wdata_d;
  logic [1:0]      err_code_q, err_code_d;
  logic [CW-1:0]   rd_idx_q, rd_idx_d;
  logic [CW-1:0]   ret_cnt_q, ret_cnt_d;
  logic [DW-1:0]   rd_sum_q, rd_sum_d;
  logic [DW-1:0]   rd_sum_nxt;
  logic [RD_LAT:0] vld_pipe_q, vld_pipe_d;
  logic            issue;

  // vld_pipe[0] marks a read address on mem_addr; vld_pipe[RD_LAT] marks its data on mem_rdata.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      word_cnt_q  <= '0;
      checksum_q  <= '0;
      mem_en_w_q  <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      err_code_q  <= '0;
      rd_idx_q    <= '0;
      ret_cnt_q   <= '0;
      rd_sum_q    <= '0;
      vld_pipe_q  <= '0;
    end else begin
      state_q     <= state_d;
      word_cnt_q  <= word_cnt_d;
      checksum_q  <= checksum_d;
      mem_en_w_q  <= mem_en_w_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      err_code_q  <= err_code_d;
      rd_idx_q    <= rd_idx_d;
      ret_cnt_q   <= ret_cnt_d;
      rd_sum_q    <= rd_sum_d;
      vld_pipe_q  <= vld_pipe_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    word_cnt_d  = word_cnt_q;
    checksum_d  = checksum_q;
    mem_en_w_d  = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    err_code_d  = err_code_q;
    rd_idx_d    = '0;
    ret_cnt_d   = '0;
    rd_sum_d    = '0;
    vld_pipe_d  = '0;
    issue       = 1'b0;
    rd_sum_nxt  = rd_sum_q + mem_rdata;

    // start overrides everything, including a coincident handshake
    if (start) begin
      state_d    = S_LOAD;
      word_cnt_d = '0;
      checksum_d = '0;
      err_code_d = '0;
    end else begin
      case (state_q)
        S_LOAD: begin
          if (ld_valid) begin
            mem_en_w_d  = 1'b1;
            mem_addr_d  = BASE_ADDR + AW'(word_cnt_q) * STEP;
            mem_wdata_d = ld_data;
            checksum_d  = checksum_q + ld_data;
            word_cnt_d  = word_cnt_q + 1'b1;
            if (ld_last) begin
              state_d = VERIFY ? S_VERIFY : S_DONE;
            end else if (word_cnt_q == LAST_IDX) begin
              state_d    = S_ERROR;
              err_code_d = 2'b01;
            end
          end
        end
        S_VERIFY: begin
          rd_idx_d  = rd_idx_q;
          ret_cnt_d = ret_cnt_q;
          rd_sum_d  = rd_sum_q;
          if (rd_idx_q < word_cnt_q) begin
            issue      = 1'b1;
            mem_addr_d = BASE_ADDR + AW'(rd_idx_q) * STEP;
            rd_idx_d   = rd_idx_q + 1'b1;
          end
          vld_pipe_d = {vld_pipe_q[RD_LAT-1:0], issue};
          if (vld_pipe_q[RD_LAT]) begin
            rd_sum_d  = rd_sum_nxt;
            ret_cnt_d = ret_cnt_q + 1'b1;
            if (ret_cnt_q == word_cnt_q - 1'b1) begin
              if (rd_sum_nxt == checksum_q) begin
                state_d = S_DONE;
              end else begin
                state_d    = S_ERROR;
                err_code_d = 2'b10;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign ld_ready  = (state_q == S_LOAD);
  assign done      = (state_q == S_DONE);
  assign err       = (state_q == S_ERROR);
  assign core_hold = (state_q != S_DONE);
  assign mem_en_w  = mem_en_w_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign err_code  = err_code_q;
  assign word_cnt  = word_cnt_q;
  assign checksum  = checksum_q;

endmodule
